tt_board_seq: RTL and testbench

- Clocked, parametrised successor to the two-colour ball board.
- Holds N coloured ball reservoirs and releases one ball at a time. Waits for the ball to come back on a colour trigger lever, or to be caught by an interceptor.
- Records every ball that reaches the bottom in a packed tray.
- Sits at the top of a puzzle: ball_out pulses drive the piece network; the network's sinks drive trigger/intercept back in.

---
 rtl/tt_board_seq.sv | 140 ++++++++++++++
 tb/tb_tt_board_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_board_seq.sv
// Clocked ball board: releases one ball at a time from NUM_COLORS reservoirs and records returns.
// Optional in-flight watchdog enabled by defining TT_WATCHDOG_EN.
module tt_board_seq #(
  parameter int unsigned NUM_COLORS      = 2,
  parameter int unsigned AMOUNT          = 10,
  parameter int unsigned TRAY_DEPTH      = 20,
  parameter int unsigned WATCHDOG_CYCLES = 64,
  localparam int unsigned CW  = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1,
  localparam int unsigned TAW = $clog2(TRAY_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_COLORS-1:0]   trigger,
  input  logic                    intercept,
  output logic [NUM_COLORS-1:0]   ball_out,
  output logic [CW-1:0]           current_color,
  output logic                    in_flight,
  output logic                    stopped,
  output logic                    no_balls,
  output logic                    tray_full,
  output logic [TRAY_DEPTH*CW-1:0] tray,
  output logic [TAW-1:0]          tray_amount,
  output logic [NUM_COLORS*8-1:0] remaining,
  output logic                    lost_ball
);

  typedef enum logic [1:0] {StIdle, StRelease, StFlight, StStopped} state_e;

  state_e        state_q;
  logic          trig_hit;
  logic [CW-1:0] trig_idx;
  logic [7:0]    rem_trig;

`ifdef TT_WATCHDOG_EN
  localparam int unsigned WDW = (WATCHDOG_CYCLES >= 256) ? $clog2(WATCHDOG_CYCLES + 1) : 8;
  logic [WDW-1:0] wd_q;
`else
  logic unused_wd_cycles;
  assign unused_wd_cycles = ^WATCHDOG_CYCLES;
  assign lost_ball = 1'b0;
`endif

  // Lowest set trigger bit wins; look up that reservoir's count.
  always_comb begin
    trig_hit = |trigger;
    trig_idx = '0;
    rem_trig = '0;
    for (int i = NUM_COLORS - 1; i >= 0; i--) begin
      if (trigger[i]) trig_idx = CW'(i);
    end
    for (int i = 0; i < NUM_COLORS; i++) begin
      if (CW'(i) == trig_idx) rem_trig = remaining[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ball_out      <= '0;
      current_color <= '0;
      in_flight     <= 1'b0;
      stopped       <= 1'b0;
      no_balls      <= 1'b0;
      tray_full     <= 1'b0;
      tray          <= '0;
      tray_amount   <= '0;
      remaining     <= {NUM_COLORS{8'(AMOUNT)}};
`ifdef TT_WATCHDOG_EN
      lost_ball     <= 1'b0;
      wd_q          <= '0;
`endif
    end else begin
      ball_out <= '0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q          <= StRelease;
            ball_out         <= NUM_COLORS'(1);
            current_color    <= '0;
            in_flight        <= 1'b1;
            remaining[7:0]   <= remaining[7:0] - 8'd1;
          end
        end
        StRelease: begin
          state_q <= StFlight;
`ifdef TT_WATCHDOG_EN
          wd_q    <= '0;
`endif
        end
        StFlight: begin
          if (intercept) begin
            state_q   <= StStopped;
            stopped   <= 1'b1;
            in_flight <= 1'b0;
          end else if (trig_hit) begin
            for (int i = 0; i < TRAY_DEPTH; i++) begin
              if (TAW'(i) == tray_amount) tray[i*CW +: CW] <= current_color;
            end
            tray_amount <= tray_amount + 1'b1;
            in_flight   <= 1'b0;
            if (tray_amount == TAW'(TRAY_DEPTH - 1)) begin
              state_q   <= StStopped;
              stopped   <= 1'b1;
              tray_full <= 1'b1;
            end else if (rem_trig == 8'd0) begin
              state_q  <= StStopped;
              stopped  <= 1'b1;
              no_balls <= 1'b1;
            end else begin
              // Next ball leaves on the very next cycle.
              state_q       <= StRelease;
              in_flight     <= 1'b1;
              current_color <= trig_idx;
              for (int i = 0; i < NUM_COLORS; i++) begin
                if (CW'(i) == trig_idx) begin
                  ball_out[i]          <= 1'b1;
                  remaining[i*8 +: 8] <= rem_trig - 8'd1;
                end
              end
            end
          end
`ifdef TT_WATCHDOG_EN
          else if (wd_q == WDW'(WATCHDOG_CYCLES - 1)) begin
            state_q   <= StStopped;
            stopped   <= 1'b1;
            lost_ball <= 1'b1;
            in_flight <= 1'b0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        StStopped: ;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_board_seq.sv
// Scoreboard bench for tt_board_seq: a board-level model predicts releases and final state.
module tb_tt_board_seq;

  localparam int NC  = 2;
  localparam int AMT = 10;
  localparam int TD  = 20;
  localparam int WD  = 8;
  localparam int CW  = 1;
  localparam int TAW = $clog2(TD + 1);

  localparam int MIdle = 0;
  localparam int MFly  = 1;
  localparam int MStop = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [NC-1:0]     trigger = '0;
  logic              intercept = 1'b0;
  logic [NC-1:0]     ball_out;
  logic [CW-1:0]     current_color;
  logic              in_flight, stopped, no_balls, tray_full, lost_ball;
  logic [TD*CW-1:0]  tray;
  logic [TAW-1:0]    tray_amount;
  logic [NC*8-1:0]   remaining;

  tt_board_seq #(
    .NUM_COLORS(NC), .AMOUNT(AMT), .TRAY_DEPTH(TD), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trigger(trigger), .intercept(intercept),
    .ball_out(ball_out), .current_color(current_color), .in_flight(in_flight),
    .stopped(stopped), .no_balls(no_balls), .tray_full(tray_full), .tray(tray),
    .tray_amount(tray_amount), .remaining(remaining), .lost_ball(lost_ball)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;

  typedef struct {
    int            color;
    logic [NC*8-1:0] rem;
    longint        at;
  } rel_t;
  rel_t exp_q[$];

  // Board model
  int     m_st, m_cur, m_nob, m_full, m_lost;
  int     m_rem[NC];
  int     m_tray[$];
  longint m_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NC*8-1:0] rem_packed();
    logic [NC*8-1:0] r;
    for (int i = 0; i < NC; i++) r[i*8 +: 8] = 8'(m_rem[i]);
    return r;
  endfunction

  task automatic model_reset();
    m_st = MIdle; m_cur = 0; m_nob = 0; m_full = 0; m_lost = 0; m_ready = 0;
    for (int i = 0; i < NC; i++) m_rem[i] = AMT;
    m_tray.delete();
    exp_q.delete();
  endtask

  task automatic model_release(input int c, input longint p);
    rel_t e;
    m_rem[c]--;
    m_cur   = c;
    e.color = c;
    e.rem   = rem_packed();
    e.at    = p;
    exp_q.push_back(e);
    m_st    = MFly;
    m_ready = p + 2;  // one release cycle before the ball can be caught
  endtask

  // p: the clock edge at which these inputs are sampled
  task automatic model_step(input logic s, input logic [NC-1:0] t, input logic ic,
                            input longint p);
    int c;
    if (m_st == MIdle) begin
      if (s) model_release(0, p);
    end else if (m_st == MFly && p >= m_ready) begin
      if (ic) begin
        m_st = MStop;
      end else if (t != 0) begin
        c = 0;
        for (int i = NC - 1; i >= 0; i--) if (t[i]) c = i;
        m_tray.push_back(m_cur);
        if (m_tray.size() == TD) begin
          m_st = MStop; m_full = 1;
        end else if (m_rem[c] == 0) begin
          m_st = MStop; m_nob = 1;
        end else begin
          model_release(c, p);
        end
      end
`ifdef TT_WATCHDOG_EN
      else if (p == m_ready + WD - 1) begin
        m_st = MStop; m_lost = 1;
      end
`endif
    end
  endtask

  task automatic drive(input logic s, input logic [NC-1:0] t, input logic ic);
    @(negedge clk);
    start = s; trigger = t; intercept = ic;
    model_step(s, t, ic, cyc + 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " ball_out"}, ball_out, 0);
    chk({tag, " remaining"}, remaining, {NC{8'(AMT)}});
    chk({tag, " tray"}, tray, 0);
    chk({tag, " tray_amount"}, tray_amount, 0);
    chk({tag, " flags"}, {stopped, no_balls, tray_full, lost_ball, in_flight}, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; start = 0; trigger = '0; intercept = 0;
    model_reset();
    #1 check_reset_vals(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic end_check(input string tag);
    logic [TD*CW-1:0] et;
    et = '0;
    foreach (m_tray[i]) et[i*CW +: CW] = CW'(m_tray[i]);
    drive(0, '0, 0);
    drive(0, '0, 0);
    @(posedge clk);
    #2;
    chk({tag, " stopped"}, stopped, m_st == MStop);
    chk({tag, " in_flight"}, in_flight, m_st == MFly);
    chk({tag, " causes"}, {no_balls, tray_full, lost_ball}, {m_nob[0], m_full[0], m_lost[0]});
    chk({tag, " tray_amount"}, tray_amount, m_tray.size());
    chk({tag, " tray"}, tray, et);
    chk({tag, " remaining"}, remaining, rem_packed());
    chk({tag, " current_color"}, current_color, m_cur);
    chk({tag, " pending releases"}, exp_q.size(), 0);
  endtask

  // Monitor: every release pulse is matched against the scoreboard.
  initial begin
    rel_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && ball_out != 0) begin
        if (exp_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected release: ball_out=%b at cycle %0d", ball_out, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("release one-hot", ball_out, 1 << e.color);
          chk("release cycle", cyc, e.at);
          chk("release color", current_color, e.color);
          chk("release remaining", remaining, e.rem);
          chk("release in_flight", in_flight, 1);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len, icp, r;
    model_reset();
    do_reset("reset");

    // Alternating colours, minimal trigger spacing
    drive(1, '0, 0);
    for (int b = 0; b < 4; b++) begin
      drive(0, '0, 0);
      drive(0, (m_cur == 0) ? 2'b10 : 2'b01, 0);
    end
    end_check("alternate");

    // Always return to blue until that reservoir runs dry
    do_reset("reset2");
    drive(1, '0, 0);
    for (int b = 0; b < 12; b++) begin
      drive(0, '0, 0);
      drive(0, 2'b01, 0);
    end
    end_check("empty");

    // Intercept beats a simultaneous trigger; everything afterwards ignored
    do_reset("reset3");
    drive(1, '0, 0);
    drive(0, '0, 0);
    drive(0, 2'b01, 0);
    drive(0, '0, 0);
    drive(0, 2'b10, 1);
    for (int b = 0; b < 3; b++) drive(1, 2'b11, 0);
    end_check("intercept");

    // Fill the tray; last trigger also meets an empty reservoir
    do_reset("reset4");
    drive(1, '0, 0);
    for (int b = 0; b < 21; b++) begin
      drive(0, '0, 0);
      drive(0, (m_cur == 0) ? 2'b10 : 2'b01, 0);
    end
    end_check("tray_full");

    // Asynchronous reset mid-cycle while stopped
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1 check_reset_vals("async reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Ball never returns: watchdog expiry or indefinite flight
    drive(1, '0, 0);
    for (int b = 0; b < 100; b++) drive(0, '0, 0);
    end_check("no return");

    // Randomised runs
    for (int run = 0; run < 24; run++) begin
      do_reset("rand reset");
      len = (run % 3 == 0) ? 150 : 50;
      icp = (run % 3 == 0) ? 0 : 4;
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 99);
        if (r < 8)             drive(1, '0, 0);
        else if (r < 8 + icp)  drive(0, NC'($urandom_range(0, 3)), 1);
        else if (r < 50)       drive(0, NC'($urandom_range(1, 3)), 0);
        else                   drive(0, '0, 0);
      end
      end_check("random");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
